// File: rtl/reg_wr_arb_pkg.sv
// Shared widths, slot record and helpers for the register-file write arbiter.
package reg_wr_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_WR_REQ = 2;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_slot_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/reg_wr_slot.sv
// One-entry write buffer for a single requester; writes to r0 are accepted but discarded.
module reg_wr_slot
    import reg_wr_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [REG_ADDR_W-1:0] in_addr,
    input  logic [REG_DATA_W-1:0] in_data,
    input  logic                  grant,
    output logic                  ready,
    output logic                  load,
    output wr_slot_t              slot
);

    wr_slot_t slot_q, slot_d;

    always_comb begin
        ready  = !slot_q.valid || grant;
        load   = in_valid && ready && (in_addr != '0);
        slot_d = slot_q;
        if (load) begin
            slot_d.valid = 1'b1;
            slot_d.addr  = in_addr;
            slot_d.data  = in_data;
        end else if (grant) begin
            slot_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;

endmodule

// File: rtl/reg_wr_arb.sv
// Two-requester register-file write arbiter. Define RR_ARB_EN for round-robin between
// different-address contenders; otherwise slot 0 has fixed priority.
module reg_wr_arb
    import reg_wr_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [REG_ADDR_W-1:0] s0_addr,
    input  logic [REG_DATA_W-1:0] s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [REG_ADDR_W-1:0] s1_addr,
    input  logic [REG_DATA_W-1:0] s1_data,
    output logic                  r3_wr,
    output logic [REG_ADDR_W-1:0] r3_addr,
    output logic [REG_DATA_W-1:0] r3_din,
    output logic [NUM_REGS-1:0]   pend_mask
);

    wr_slot_t                slot0, slot1;
    logic [NUM_WR_REQ-1:0]   grant;
    logic [NUM_WR_REQ-1:0]   load;
    logic                    both_valid;
    logic                    any_valid;
    logic                    gnt_sel;
    logic                    pref;
    logic                    older_q, older_d;  // 1: slot 1 holds the older entry

    reg_wr_slot u_slot0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s0_valid),
        .in_addr  (s0_addr),
        .in_data  (s0_data),
        .grant    (grant[0]),
        .ready    (s0_ready),
        .load     (load[0]),
        .slot     (slot0)
    );

    reg_wr_slot u_slot1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (s1_valid),
        .in_addr  (s1_addr),
        .in_data  (s1_data),
        .grant    (grant[1]),
        .ready    (s1_ready),
        .load     (load[1]),
        .slot     (slot1)
    );

    assign both_valid = slot0.valid && slot1.valid;
    assign any_valid  = slot0.valid || slot1.valid;

`ifdef RR_ARB_EN
    logic rr_q;

    assign pref = rr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else if (both_valid) begin
            rr_q <= ~gnt_sel;
        end
    end
`else
    assign pref = 1'b0;
`endif

    always_comb begin
        gnt_sel = 1'b0;
        if (both_valid) begin
            // Same destination must retire in arrival order, whatever the policy says.
            gnt_sel = (slot0.addr == slot1.addr) ? older_q : pref;
        end else if (slot1.valid) begin
            gnt_sel = 1'b1;
        end
        grant = '0;
        if (any_valid) begin
            grant[gnt_sel] = 1'b1;
        end
    end

    always_comb begin
        r3_wr   = 1'b0;
        r3_addr = '0;
        r3_din  = '0;
        if (any_valid) begin
            r3_wr   = 1'b1;
            r3_addr = gnt_sel ? slot1.addr : slot0.addr;
            r3_din  = gnt_sel ? slot1.data : slot0.data;
        end
    end

    // A lone load makes the other slot older; a simultaneous load ranks slot 0 older.
    always_comb begin
        older_d = older_q;
        unique case (load)
            2'b01:   older_d = 1'b1;
            2'b10:   older_d = 1'b0;
            2'b11:   older_d = 1'b0;
            default: older_d = older_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            older_q <= 1'b0;
        end else begin
            older_q <= older_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (slot0.valid) pend_mask = pend_mask | addr_onehot(slot0.addr);
        if (slot1.valid) pend_mask = pend_mask | addr_onehot(slot1.addr);
    end

endmodule

// File: tb/tb_reg_wr_arb.sv
// Directed and randomized bench for reg_wr_arb against a timestamp-ordered reference model.
module tb_reg_wr_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        r3_wr;
    logic [4:0]  r3_addr;
    logic [31:0] r3_din;
    logic [31:0] pend_mask;

`ifdef RR_ARB_EN
    localparam bit RoundRobin = 1'b1;
`else
    localparam bit RoundRobin = 1'b0;
`endif

    reg_wr_arb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s0_valid  (s0_valid),
        .s0_ready  (s0_ready),
        .s0_addr   (s0_addr),
        .s0_data   (s0_data),
        .s1_valid  (s1_valid),
        .s1_ready  (s1_ready),
        .s1_addr   (s1_addr),
        .s1_data   (s1_data),
        .r3_wr     (r3_wr),
        .r3_addr   (r3_addr),
        .r3_din    (r3_din),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: each buffered write carries the cycle it arrived in.
    bit          m_v[2];
    logic [4:0]  m_a[2];
    logic [31:0] m_d[2];
    int          m_stamp[2];
    bit          m_ptr;
    int          cyc = 0;
    int          e_g = -1;
    bit          e_rdy[2];
    logic [31:0] w7_q[$];

    task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] a1, input logic [31:0] d1);
        s0_valid = v0; s0_addr = a0; s0_data = d0;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
    endtask

    task automatic sample();
        logic [31:0] e_pend;
        #1;
        e_g = -1;
        if (m_v[0] && m_v[1]) begin
            if (m_a[0] == m_a[1]) e_g = (m_stamp[1] < m_stamp[0]) ? 1 : 0;
            else                  e_g = RoundRobin ? int'(m_ptr) : 0;
        end else if (m_v[0]) begin
            e_g = 0;
        end else if (m_v[1]) begin
            e_g = 1;
        end
        e_pend = '0;
        for (int n = 0; n < 2; n++) begin
            if (m_v[n]) e_pend[m_a[n]] = 1'b1;
            e_rdy[n] = !m_v[n] || (e_g == n);
        end
        check_eq("r3_wr", 32'(r3_wr), 32'(e_g >= 0));
        check_eq("r3_addr", 32'(r3_addr), (e_g >= 0) ? 32'(m_a[e_g]) : 32'd0);
        check_eq("r3_din", r3_din, (e_g >= 0) ? m_d[e_g] : 32'd0);
        check_eq("pend_mask", pend_mask, e_pend);
        check_eq("s0_ready", 32'(s0_ready), 32'(e_rdy[0]));
        check_eq("s1_ready", 32'(s1_ready), 32'(e_rdy[1]));
        if (r3_wr === 1'b1 && r3_addr == 5'd7) w7_q.push_back(r3_din);
    endtask

    task automatic tick();
        bit          sv[2];
        logic [4:0]  sa[2];
        logic [31:0] sd[2];
        bit          rst;
        bit          contested;
        sv[0] = s0_valid; sa[0] = s0_addr; sd[0] = s0_data;
        sv[1] = s1_valid; sa[1] = s1_addr; sd[1] = s1_data;
        rst = !rst_n;
        contested = m_v[0] && m_v[1];
        @(posedge clk);
        if (rst) begin
            m_v[0] = 0; m_v[1] = 0; m_ptr = 0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (sv[n] && e_rdy[n] && sa[n] != 5'd0) begin
                    m_v[n] = 1; m_a[n] = sa[n]; m_d[n] = sd[n]; m_stamp[n] = cyc;
                end else if (e_g == n) begin
                    m_v[n] = 0;
                end
            end
            if (contested) m_ptr = (e_g == 0);
        end
        cyc++;
        e_g = -1;
        @(negedge clk);
    endtask

    task automatic step();
        sample();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        e_rdy[0] = 1; e_rdy[1] = 1;
        @(negedge clk);
        tick();
        tick();
        sample();
        check_eq("rst_s0_ready", 32'(s0_ready), 32'd1);
        check_eq("rst_s1_ready", 32'(s1_ready), 32'd1);
        tick();
        rst_n = 1'b1;

        // Single write
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        check_eq("single_wr", 32'(r3_wr), 32'd1);
        check_eq("single_addr", 32'(r3_addr), 32'd5);
        check_eq("single_din", r3_din, 32'hDEADBEEF);
        check_eq("single_pend", pend_mask, 32'h20);
        tick();
        sample();
        check_eq("single_pend_clr", pend_mask, 32'h0);
        tick();

        // Contention on the same edge
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        step();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        check_eq("contend_first", 32'(r3_addr), 32'd3);
        tick();
        sample();
        check_eq("contend_second", 32'(r3_addr), 32'd4);
        tick();
        drive(1, 8, 32'h88, 1, 9, 32'h99);
        step();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        check_eq("contend2_first", 32'(r3_addr), RoundRobin ? 32'd9 : 32'd8);
        tick();
        step();

        // Same-address ordering with slot 1 held behind slot 0
        w7_q.delete();
        drive(1, 9, 32'hA, 1, 7, 32'd1);
        step();
        drive(1, 7, 32'd2, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();
        check_eq("w7_count", 32'(w7_q.size()), 32'd2);
        if (w7_q.size() == 2) begin
            check_eq("w7_first", w7_q[0], 32'd1);
            check_eq("w7_second", w7_q[1], 32'd2);
        end

        // r0 suppression
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        sample();
        check_eq("r0_ready", 32'(s0_ready), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        sample();
        check_eq("r0_wr", 32'(r3_wr), 32'd0);
        check_eq("r0_pend", pend_mask, 32'd0);
        tick();

        // Back-to-back streaming
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) drive(1, 5'(i), 32'(i * 17), 0, 0, 0);
            else        drive(0, 0, 0, 0, 0, 0);
            sample();
            if (i <= 4) check_eq("stream_ready", 32'(s0_ready), 32'd1);
            if (i >= 2) begin
                check_eq("stream_wr", 32'(r3_wr), 32'd1);
                check_eq("stream_addr", 32'(r3_addr), 32'(i - 1));
            end
            tick();
        end

        // Reset mid-operation
        drive(1, 10, 32'hAA, 1, 11, 32'hBB);
        step();
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sample();
        check_eq("mid_rst_wr", 32'(r3_wr), 32'd0);
        check_eq("mid_rst_pend", pend_mask, 32'd0);
        check_eq("mid_rst_s0_ready", 32'(s0_ready), 32'd1);
        check_eq("mid_rst_s1_ready", 32'(s1_ready), 32'd1);
        tick();

        // Randomized traffic with narrow addresses to force collisions
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
            step();
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_wr_arb.md
REG_WR_ARB -- requirements
Module: reg_wr_arb

Interface
REQ-001 The block SHALL have one clock `clk` and one reset `rst_n`; reset is synchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- s0_valid  in  1  requester 0 (ALU writeback) write request
- s0_ready  out  1  requester 0 accept
- s0_addr  in  5  requester 0 destination register
- s0_data  in  32  requester 0 write data
- s1_valid  in  1  requester 1 (load/MDU writeback) write request
- s1_ready  out  1  requester 1 accept
- s1_addr  in  5  requester 1 destination register
- s1_data  in  32  requester 1 write data
- r3_wr  out  1  register-file write enable
- r3_addr  out  5  register-file write address
- r3_din  out  32  register-file write data
- pend_mask  out  32  bit n set = a write to register n is buffered and not yet issued

Function
REQ-003 Each requester SHALL own a one-entry slot (valid, addr, data); a transfer occurs on a rising edge with sN_valid=1 and sN_ready=1.
REQ-004 sN_ready SHALL be 1 when slot N is empty or slot N is granted in the current cycle, allowing back-to-back transfers.
REQ-005 A transfer with addr=0 SHALL be accepted but SHALL NOT load the slot; it never reaches r3_wr.
REQ-006 Grant SHALL be computed combinationally from registered slot state only; input ports never drive r3_* in the same cycle.
- Minimum latency is 1 cycle: transfer at edge k, r3_wr=1 during cycle k+1.
REQ-007 Exactly one slot SHALL be granted per cycle when any slot is valid; r3_wr=1 with the granted slot's addr and data.
REQ-008 With no valid slot, r3_wr, r3_addr and r3_din SHALL be 0.
REQ-009 With both slots valid and different addresses, the arbitration policy (REQ-016) SHALL select the grant.
REQ-010 With both slots valid and equal addresses, the older slot SHALL be granted first; slots loaded on the same edge count slot 0 as older.
- An age bit, updated on every slot load, SHALL record which slot is older.
REQ-011 A granted slot SHALL empty at the next edge unless it reloads on the same edge.
REQ-012 pend_mask SHALL be the OR of one-hot(slot addr) over the valid slots; it includes the slot being issued this cycle.
REQ-013 A slot SHALL hold its contents while not granted; no entry is dropped or overwritten.

Reset
REQ-014 While rst_n=0 at an edge, both slots SHALL empty, the age bit SHALL clear, and the round-robin pointer SHALL go to 0.
- After reset: r3_wr=0, r3_addr=0, r3_din=0, pend_mask=0, s0_ready=1, s1_ready=1.
REQ-015 Reset during pending writes SHALL discard them with no r3_wr pulse in the following cycle.

Configuration
REQ-016 Macro RR_ARB_EN SHALL select the arbitration policy for REQ-009.
- Defined: round-robin. A 1-bit pointer names the preferred slot and toggles to the other slot after each contested grant.
- Undefined: fixed priority, slot 0 always wins, and no pointer register exists.
- In both cases REQ-010 overrides the policy.

Structure
REQ-017 A shared package SHALL hold REG_ADDR_W=5, REG_DATA_W=32, NUM_WR_REQ=2, and a slot struct typedef {valid, addr, data}.
REQ-018 The one-entry buffer SHALL be a sub-module `reg_wr_slot`, instantiated twice; arbitration, the age bit and pend_mask live in the top level.

Verification
REQ-019 Single write: s0 writes addr 5, data 0xDEADBEEF at edge k -> cycle k+1 shows r3_wr=1, r3_addr=5, r3_din=0xDEADBEEF, and pend_mask=0x20 during that cycle; cycle k+2 shows pend_mask=0.
REQ-020 Contention: s0 (addr 3) and s1 (addr 4) are loaded on the same edge.
- Fixed priority: r3_addr=3, then 4.
- RR_ARB_EN: r3_addr=3, then 4; the next contested pair grants slot 1 first.
REQ-021 Same-address ordering: s1 writes addr 7, data 1 at edge k, and s0 writes addr 7, data 2 at edge k+1 while slot 1 is still held -> r3 writes 7←1 before 7←2 under either policy.
REQ-022 r0 suppression: s0 writes addr 0, data 0xFFFFFFFF -> s0_ready=1, and r3_wr and pend_mask stay 0.
REQ-023 Back-to-back streaming: s0_valid is held 1 for 4 cycles with addrs 1..4 and s1 idle -> s0_ready stays 1, and r3_wr=1 with addrs 1,2,3,4 on consecutive cycles.
REQ-024 Reset mid-operation: both slots are full and rst_n=0 for one edge -> the next cycle shows r3_wr=0, pend_mask=0, and both readies 1.
